// File: rtl/bridge_uart_tx_if.sv
// bridge_uart_tx_if: Bridge device-bus signals between the CPU side (master) and the UART responder (slave)
interface bridge_uart_tx_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/bridge_uart_tx.sv
// bridge_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and drain IRQ; optional parity via UART_PARITY_EN
module bridge_uart_tx #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
  input  logic              clk,
  input  logic              reset,
  bridge_uart_tx_if.slave   bus,
  output logic              txd
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t          st, nx;
  logic            txen, irqen, ovf, irq_q;
  logic [15:0]     div_q, fdiv, tmr;
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic [8:0]      cnt_x;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [7:0]      sh;
  logic [2:0]      bidx;
  logic            pop, tick, full, empty, busy, wr_ok;
  logic            wr_ctrl, wr_stat, wr_data, wr_div;
  logic [31:0]     ctrl_rd, stat_rd;
  logic            unused_ok;
`ifdef UART_PARITY_EN
  logic            pen, odd, fpen, par;
`endif
  assign wr_ctrl   = bus.WE && bus.Addr[3:2] == 2'd0;
  assign wr_stat   = bus.WE && bus.Addr[3:2] == 2'd1;
  assign wr_data   = bus.WE && bus.Addr[3:2] == 2'd2;
  assign wr_div    = bus.WE && bus.Addr[3:2] == 2'd3;
  assign empty     = cnt == '0;
  assign full      = cnt == CW'(FIFO_DEPTH);
  assign busy      = st != IDLE;
  assign tick      = busy && tmr == fdiv;
  assign wr_ok     = wr_data && (!full || pop);
  assign cnt_x     = 9'(cnt);
  assign unused_ok = ^{bus.Din[31:16], bus.Addr[31:4]};
`ifdef UART_PARITY_EN
  assign ctrl_rd   = {28'd0, odd, pen, irqen, txen};
`else
  assign ctrl_rd   = {30'd0, irqen, txen};
`endif
  assign stat_rd   = {20'd0, ovf, busy, empty, full, cnt_x[7:0]};
  assign bus.Dout  = bus.Addr[3:2] == 2'd0 ? ctrl_rd :
                     bus.Addr[3:2] == 2'd1 ? stat_rd :
                     bus.Addr[3:2] == 2'd3 ? {16'd0, div_q} : 32'd0;
  assign bus.IRQ   = irq_q;
  // Control registers, divisor and the sticky overflow flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      txen  <= 1'b0;
      irqen <= 1'b0;
      div_q <= DEFAULT_DIV;
      ovf   <= 1'b0;
`ifdef UART_PARITY_EN
      pen   <= 1'b0;
      odd   <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) {irqen, txen} <= bus.Din[1:0];
`ifdef UART_PARITY_EN
      if (wr_ctrl) {odd, pen} <= bus.Din[3:2];
`endif
      if (wr_div) div_q <= bus.Din[15:0] == '0 ? 16'd1 : bus.Din[15:0];
      if (wr_data && full && !pop) ovf <= 1'b1;
      else if (wr_stat && bus.Din[11]) ovf <= 1'b0;
    end
  // FIFO pointers and occupancy; a pop in the same cycle frees the slot for a push to a full FIFO
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(wr_ok) - CW'(pop);
    end
  // FIFO storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= bus.Din[7:0];
  // Frame datapath: load on pop (latching divisor and parity mode), then bit timer and shifter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st   <= IDLE;
      sh   <= '0;
      fdiv <= DEFAULT_DIV;
      tmr  <= '0;
      bidx <= '0;
`ifdef UART_PARITY_EN
      fpen <= 1'b0;
      par  <= 1'b0;
`endif
    end else begin
      st <= nx;
      if (pop) begin
        sh   <= mem[rp];
        fdiv <= div_q;
        tmr  <= '0;
        bidx <= '0;
`ifdef UART_PARITY_EN
        fpen <= pen;
        par  <= ^mem[rp] ^ odd;
`endif
      end else if (tick) begin
        tmr <= '0;
        if (st == DATA) begin
          sh   <= sh >> 1;
          bidx <= bidx + 3'd1;
        end
      end else if (busy) tmr <= tmr + 16'd1;
    end
  // Next-state and pop decision; STOP chains straight into START when more data is ready
  always_comb begin
    nx  = st;
    pop = 1'b0;
    case (st)
      IDLE:   if (txen && !empty) begin pop = 1'b1; nx = START; end
      START:  if (tick) nx = DATA;
`ifdef UART_PARITY_EN
      DATA:   if (tick && bidx == 3'd7) nx = fpen ? PARITY : STOP;
      PARITY: if (tick) nx = STOP;
`else
      DATA:   if (tick && bidx == 3'd7) nx = STOP;
`endif
      STOP:   if (tick) begin
                pop = txen && !empty;
                nx  = (txen && !empty) ? START : IDLE;
              end
      default: nx = IDLE;
    endcase
  end
  // Serial line driven from state so an async reset forces idle-high immediately
  always_comb
`ifdef UART_PARITY_EN
    txd = st == START ? 1'b0 : st == DATA ? sh[0] : st == PARITY ? par : 1'b1;
`else
    txd = st == START ? 1'b0 : st == DATA ? sh[0] : 1'b1;
`endif
  // Drain interrupt, registered one cycle behind its condition
  always_ff @(posedge clk or negedge reset)
    if (!reset) irq_q <= 1'b0;
    else irq_q <= irqen && txen && empty && !busy;
endmodule

// File: tb/tb_bridge_uart_tx.sv
// tb_bridge_uart_tx: scoreboard bench for bridge_uart_tx; frames checked cycle by cycle against expected bytes
module tb_bridge_uart_tx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic txd;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  bridge_uart_tx_if bus();
  bridge_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_DIV(16'd15)) dut (
    .clk(clk), .reset(reset), .bus(bus), .txd(txd)
  );
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.Addr = {28'd0, a};
    bus.WE   = 1'b1;
    bus.Din  = d;
    @(negedge clk);
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = {28'd0, a};
    #1 d = bus.Dout;
  endtask

  task automatic push_byte(input logic [7:0] b);
    sb.push_back(b);
    wr(2'd2, {24'd0, b});
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit pen, input bit odd);
    return pen ? {1'b1, ^b ^ odd, b, 1'b0} : {2'b01, b, 1'b0};
  endfunction

  // Waits for a start bit, then records every cycle of nb bit periods
  task automatic rx_frame(input int div, input int nb, output logic [10:0] fr, output int lat,
                          output logic [7:0] cnt0, output bit stable, output bit irq_seen);
    logic [31:0] t;
    fr = '0; lat = 0; cnt0 = '0; stable = 1'b1; irq_seen = 1'b0;
    do begin @(negedge clk); lat++; end while (txd !== 1'b0 && lat < 3000);
    if (txd !== 1'b0) return;
    rd(2'd1, t);
    cnt0 = t[7:0];
    for (int k = 0; k < nb; k++)
      for (int c = 0; c <= div; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (c == 0) fr[k] = txd;
        else if (txd !== fr[k]) stable = 1'b0;
        irq_seen |= bus.IRQ;
      end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    bit bad;
    repeat (3) @(negedge clk);
    rd(2'd3, d); checks++;
    if (d !== 32'd15) begin errors++; $display("FAIL reset_div got %h expected %h", d, 32'd15); end
    rd(2'd1, d); checks++;
    if (d !== 32'h200) begin errors++; $display("FAIL reset_stat got %h expected %h", d, 32'h200); end
    rd(2'd0, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h expected %h", d, 32'd0); end
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b expected 1", txd); end
    checks++;
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b expected 0", bus.IRQ); end
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (100) begin @(negedge clk); if (txd !== 1'b1) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL idle_txd got activity expected steady 1"); end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    logic [31:0] e;
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, d);
`ifdef UART_PARITY_EN
    e = 32'hF;
`else
    e = 32'h3;
`endif
    checks++;
    if (d !== e) begin errors++; $display("FAIL ctrl_mask got %h expected %h", d, e); end
    wr(2'd0, 32'd0);
    wr(2'd3, 32'd0);
    rd(2'd3, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL div_zero got %h expected %h", d, 32'd1); end
  endtask

  task automatic test_frame;
    logic [31:0] d;
    logic [10:0] fr, e;
    logic [7:0] c0;
    int lat;
    bit st, irq;
    wr(2'd3, 32'd3);
    wr(2'd0, 32'd1);
    push_byte(8'hA5);
    rd(2'd1, d); checks++;
    if (d !== 32'h001) begin errors++; $display("FAIL frame_pre_stat got %h expected %h", d, 32'h001); end
    rx_frame(3, 10, fr, lat, c0, st, irq);
    e = mk(sb.pop_front(), 1'b0, 1'b0);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL frame_latency got %0d expected 1", lat); end
    checks++;
    if (fr !== e || !st) begin errors++; $display("FAIL frame_a5 got %h stable %0d expected %h", fr, st, e); end
    checks++;
    if (c0 !== 8'd0) begin errors++; $display("FAIL frame_count got %0d expected 0", c0); end
    @(negedge clk);
    rd(2'd1, d); checks++;
    if (txd !== 1'b1 || d !== 32'h200) begin
      errors++; $display("FAIL frame_end got txd %b stat %h expected txd 1 stat 200", txd, d);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] fr, e;
    logic [7:0] c0;
    int lat;
    bit st, irq;
    wr(2'd0, 32'd0);
    for (int i = 1; i <= 3; i++) push_byte(8'(i));
    wr(2'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      rx_frame(3, 10, fr, lat, c0, st, irq);
      e = mk(sb.pop_front(), 1'b0, 1'b0);
      checks++;
      if (fr !== e || !st) begin errors++; $display("FAIL b2b_frame%0d got %h expected %h", i, fr, e); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL b2b_gap%0d got %0d expected 1", i, lat); end
      checks++;
      if (c0 !== 8'(2 - i)) begin errors++; $display("FAIL b2b_count%0d got %0d expected %0d", i, c0, 2 - i); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    wr(2'd0, 32'd0);
    for (int i = 0; i < 16; i++) wr(2'd2, 32'(i));
    rd(2'd1, d); checks++;
    if (d !== 32'h110) begin errors++; $display("FAIL fifo_full got %h expected %h", d, 32'h110); end
    wr(2'd2, 32'hEE);
    rd(2'd1, d); checks++;
    if (d !== 32'h910) begin errors++; $display("FAIL fifo_ovf got %h expected %h", d, 32'h910); end
    wr(2'd1, 32'h800);
    rd(2'd1, d); checks++;
    if (d !== 32'h110) begin errors++; $display("FAIL ovf_clear got %h expected %h", d, 32'h110); end
    @(negedge clk);
    reset = 1'b0;
    rd(2'd1, d); checks++;
    if (d !== 32'h200) begin errors++; $display("FAIL ovf_reset got %h expected %h", d, 32'h200); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_irq;
    logic [10:0] fr, e;
    logic [7:0] c0;
    int lat;
    bit st, irq;
    wr(2'd3, 32'd3);
    wr(2'd0, 32'd3);
    checks++;
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL irq_delay got %b expected 0", bus.IRQ); end
    @(negedge clk); checks++;
    if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL irq_set got %b expected 1", bus.IRQ); end
    push_byte(8'h3C);
    rx_frame(3, 10, fr, lat, c0, st, irq);
    e = mk(sb.pop_front(), 1'b0, 1'b0);
    checks++;
    if (fr !== e || !st) begin errors++; $display("FAIL irq_frame got %h expected %h", fr, e); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_busy got %b expected 0", irq); end
    @(negedge clk); checks++;
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL irq_after_stop got %b expected 0", bus.IRQ); end
    @(negedge clk); checks++;
    if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL irq_return got %b expected 1", bus.IRQ); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    int n;
    bit bad;
    push_byte(8'h55);
    n = 0;
    do begin @(negedge clk); n++; end while (txd !== 1'b0 && n < 3000);
    repeat (9) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin errors++; $display("FAIL mid_data got %b expected 0", txd); end
    #2 reset = 1'b0;
    #1; checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL mid_reset_txd got %b expected 1", txd); end
    rd(2'd1, d); checks++;
    if (d !== 32'h200) begin errors++; $display("FAIL mid_reset_stat got %h expected %h", d, 32'h200); end
    rd(2'd0, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL mid_reset_ctrl got %h expected %h", d, 32'd0); end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (100) begin @(negedge clk); if (txd !== 1'b1) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL residual_frame got activity expected steady 1"); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    logic [10:0] fr, e;
    logic [7:0] c0;
    int lat;
    bit st, irq;
    wr(2'd3, 32'd3);
    wr(2'd0, 32'h5);
    push_byte(8'h07);
    rx_frame(3, 11, fr, lat, c0, st, irq);
    e = mk(sb.pop_front(), 1'b1, 1'b0);
    checks++;
    if (fr !== e || !st) begin errors++; $display("FAIL parity_frame got %h expected %h", fr, e); end
  endtask
`endif

  initial begin
    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.Din  = '0;
    test_reset();
    test_regs();
    test_frame();
    test_back_to_back();
    test_overflow();
    test_irq();
    test_reset_mid_frame();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
